// File: rtl/port_strobe_sequencer.sv
// rtl/port_strobe_sequencer.sv - timed setup/pulse/hold strobe sequencer for NPORTS active-low port selects
//
// Purpose: latches a port address from the data bus and, for each accepted request, drives one
// registered, glitch-free active-low select on the write or read bus for a timed strobe window.
// Optional feature macro: PORT_WAIT_EN (adds port_wait, stretching the strobe for slow ports).
//
// Ports:
//   clk           in   1       system clock
//   reset         in   1       synchronous reset, active high
//   data          in   DATA_W  address source, low ADDR_BITS used
//   _portsel_in   in   1       active-low address load enable
//   req_valid     in   1       transaction request
//   req_wr        in   1       1 = write strobe, 0 = read strobe
//   port_wait     in   1       slow-port stretch request (PORT_WAIT_EN only)
//   req_ready     out  1       high in IDLE when not in reset
//   _port_sel_wr  out  NPORTS  active-low write selects, one-cold
//   _port_sel_rd  out  NPORTS  active-low read selects, one-cold
//   busy          out  1       high in SETUP/STROBE/HOLD
//   done          out  1       one-cycle completion pulse
module port_strobe_sequencer #(
    parameter int ADDR_BITS = 4,
    parameter int DATA_W    = 8,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1,
    localparam int NPORTS   = 2 ** ADDR_BITS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data,
    input  logic              _portsel_in,
    input  logic              req_valid,
    input  logic              req_wr,
`ifdef PORT_WAIT_EN
    input  logic              port_wait,
`endif
    output logic              req_ready,
    output logic [NPORTS-1:0] _port_sel_wr,
    output logic [NPORTS-1:0] _port_sel_rd,
    output logic              busy,
    output logic              done
);

    localparam int CNT_MAX_SP = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int CNT_MAX    = (CNT_MAX_SP > HOLD_CYC) ? CNT_MAX_SP : HOLD_CYC;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);

    // Reload values are "cycles minus one": the counter reaches zero in the last cycle of a phase.
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'((SETUP_CYC > 0) ? SETUP_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [ADDR_BITS-1:0]   r_addr;
    logic [ADDR_BITS-1:0]   r_shadow;
    logic                   r_pending;
    logic [ADDR_BITS-1:0]   r_txn_addr;
    logic                   r_txn_wr;
    logic [NPORTS-1:0]      r_sel_wr;
    logic [NPORTS-1:0]      r_sel_rd;
    logic                   r_done;
    logic                   w_accept;
    logic                   w_fin;
    logic                   w_wait;
    logic                   w_load;
    logic [ADDR_BITS-1:0]   w_sel_addr;
    logic                   w_sel_is_wr;
    logic [NPORTS-1:0]      w_onehot;
    logic                   w_unused_data;

`ifdef PORT_WAIT_EN
    assign w_wait = port_wait;
`else
    assign w_wait = 1'b0;
`endif

    assign w_unused_data = ^data;
    assign w_load        = ~_portsel_in;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = (r_cnt != '0) ? r_cnt - 1'b1 : r_cnt;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_accept = 1'b1;
                    if (SETUP_CYC > 0) begin
                        w_state_nxt = S_SETUP;
                        w_cnt_nxt   = SETUP_LD;
                    end else begin
                        w_state_nxt = S_STROBE;
                        w_cnt_nxt   = PULSE_LD;
                    end
                end
            end
            S_SETUP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_STROBE;
                    w_cnt_nxt   = PULSE_LD;
                end
            end
            S_STROBE: begin
                // Minimum pulse must elapse, then a slow port may keep the strobe low.
                if (r_cnt == '0 && !w_wait) begin
                    if (HOLD_CYC > 0) begin
                        w_state_nxt = S_HOLD;
                        w_cnt_nxt   = HOLD_LD;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_HOLD: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_fin = (r_state != S_IDLE) && (w_state_nxt == S_IDLE);

    // With SETUP skipped the strobe starts on the accept edge, so use the live snapshot source.
    assign w_sel_addr  = w_accept ? r_addr : r_txn_addr;
    assign w_sel_is_wr = w_accept ? req_wr : r_txn_wr;
    assign w_onehot    = {{(NPORTS-1){1'b0}}, 1'b1} << w_sel_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_shadow   <= '0;
            r_pending  <= 1'b0;
            r_txn_addr <= '0;
            r_txn_wr   <= 1'b0;
            r_sel_wr   <= '1;
            r_sel_rd   <= '1;
            r_done     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_fin;

            // Selects are registered from next state so they never glitch.
            r_sel_wr <= (w_state_nxt == S_STROBE &&  w_sel_is_wr) ? ~w_onehot : '1;
            r_sel_rd <= (w_state_nxt == S_STROBE && !w_sel_is_wr) ? ~w_onehot : '1;

            if (w_accept) begin
                r_txn_addr <= r_addr;
                r_txn_wr   <= req_wr;
            end

            // A load landing on the return-to-IDLE edge is newer than the shadow, so it wins.
            if (w_load && (r_state == S_IDLE || w_fin)) begin
                r_addr    <= data[ADDR_BITS-1:0];
                r_pending <= 1'b0;
            end else if (w_load) begin
                r_shadow  <= data[ADDR_BITS-1:0];
                r_pending <= 1'b1;
            end else if (w_fin && r_pending) begin
                r_addr    <= r_shadow;
                r_pending <= 1'b0;
            end
        end
    end

    assign req_ready    = (r_state == S_IDLE) && !reset;
    assign busy         = (r_state != S_IDLE);
    assign done         = r_done;
    assign _port_sel_wr = r_sel_wr;
    assign _port_sel_rd = r_sel_rd;

endmodule

// File: tb/tb_port_strobe_sequencer.sv
// tb/tb_port_strobe_sequencer.sv - scoreboard bench for port_strobe_sequencer
module tb_port_strobe_sequencer;

    localparam int SETUP = 1;
    localparam int PULSE = 2;
    localparam int HOLD  = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  data;
    logic        _portsel_in;
    logic        req_valid;
    logic        req_wr;
    logic        req_ready;
    logic [15:0] _port_sel_wr;
    logic [15:0] _port_sel_rd;
    logic        busy;
    logic        done;
`ifdef PORT_WAIT_EN
    logic        port_wait;
`endif

    port_strobe_sequencer #(
        .ADDR_BITS(4), .DATA_W(8), .SETUP_CYC(SETUP), .PULSE_CYC(PULSE), .HOLD_CYC(HOLD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .data         (data),
        ._portsel_in  (_portsel_in),
        .req_valid    (req_valid),
        .req_wr       (req_wr),
`ifdef PORT_WAIT_EN
        .port_wait    (port_wait),
`endif
        .req_ready    (req_ready),
        ._port_sel_wr (_port_sel_wr),
        ._port_sel_rd (_port_sel_rd),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic       wr;
        logic [3:0] addr;
        int         len;
        int         start;
    } exp_t;

    exp_t sb[$];

    // Strobe monitor: reconstructs each strobe and compares it with the scoreboard head.
    bit          in_strb   = 1'b0;
    int          s_len     = 0;
    int          s_start   = 0;
    int          last_end  = 0;
    logic [15:0] s_pat;
    logic        s_wr;
    logic        prev_done = 1'b0;

    always @(negedge clk) begin
        logic        act_w;
        logic        act_r;
        logic [15:0] cur;
        logic [15:0] one;
        logic [15:0] exp_pat;
        exp_t        e;
        if (reset) begin
            in_strb   = 1'b0;
            prev_done = 1'b0;
        end else begin
            act_w = (_port_sel_wr !== 16'hFFFF);
            act_r = (_port_sel_rd !== 16'hFFFF);
            if (act_w && act_r) check("both_low", 1, 0);
            if (act_w || act_r) begin
                check("busy_in_strobe", busy, 1);
                cur = act_w ? _port_sel_wr : _port_sel_rd;
                if (!in_strb) begin
                    in_strb = 1'b1;
                    s_len   = 0;
                    s_start = cyc;
                    s_pat   = cur;
                    s_wr    = act_w;
                end else begin
                    check("strobe_stable", cur, s_pat);
                end
                s_len++;
                last_end = cyc;
            end else if (in_strb) begin
                in_strb = 1'b0;
                if (sb.size() == 0) begin
                    check("sb_underflow", 0, 1);
                end else begin
                    e       = sb.pop_front();
                    one     = 16'h0001;
                    exp_pat = ~(one << e.addr);
                    check("strobe_dir", s_wr, e.wr);
                    check("strobe_pat", s_pat, exp_pat);
                    check("strobe_len", s_len, e.len);
                    check("strobe_start", s_start, e.start);
                end
            end
            if (done) begin
                check("done_lat", cyc - last_end, HOLD + 1);
                check("done_single", prev_done, 0);
            end
            prev_done = done;
        end
    end

    task automatic load(input logic [7:0] v);
        @(negedge clk);
        data        = v;
        _portsel_in = 1'b0;
        @(negedge clk);
        _portsel_in = 1'b1;
    endtask

    task automatic send(input logic wr, input logic [3:0] exp_addr, input int exp_len,
                        input logic ld, input logic [7:0] ldv);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("ready_timeout", 0, 1);
        req_valid = 1'b1;
        req_wr    = wr;
        if (ld) begin
            data        = ldv;
            _portsel_in = 1'b0;
        end
        sb.push_back('{wr, exp_addr, exp_len, cyc + 1 + SETUP});
        @(negedge clk);
        req_valid   = 1'b0;
        _portsel_in = 1'b1;
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!done) check("done_timeout", 0, 1);
        else       check("ready_at_done", req_ready, 1);
    endtask

    initial begin
        reset       = 1'b1;
        data        = '0;
        _portsel_in = 1'b1;
        req_valid   = 1'b0;
        req_wr      = 1'b0;
`ifdef PORT_WAIT_EN
        port_wait   = 1'b0;
`endif
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_wr", _port_sel_wr, 16'hFFFF);
        check("rst_rd", _port_sel_rd, 16'hFFFF);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ready_low", req_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("ready_after_rst", req_ready, 1);

        // Write to port 2
        load(8'd2);
        send(1'b1, 4'd2, PULSE, 1'b0, 8'd0);

        // Read port 15; same-edge load of 3 only affects the next transaction
        load(8'd15);
        send(1'b0, 4'd15, PULSE, 1'b1, 8'd3);
        send(1'b0, 4'd3, PULSE, 1'b0, 8'd0);

        // Load during busy goes to shadow and applies on return to IDLE
        load(8'd2);
        fork
            send(1'b1, 4'd2, PULSE, 1'b0, 8'd0);
            begin
                repeat (3) @(negedge clk);
                load(8'd5);
            end
        join
        send(1'b1, 4'd5, PULSE, 1'b0, 8'd0);

        // Upper data bits are ignored
        load(8'hA6);
        send(1'b0, 4'd6, PULSE, 1'b0, 8'd0);

        // Assorted transactions
        for (int i = 0; i < 6; i++) begin
            logic [3:0] a;
            logic       w;
            a = 4'($urandom_range(0, 15));
            w = 1'($urandom_range(0, 1));
            load({4'h0, a});
            send(w, a, PULSE, 1'b0, 8'd0);
        end

        // Reset during STROBE with a pending shadow load
        load(8'd4);
        @(negedge clk);
        req_valid = 1'b1;
        req_wr    = 1'b1;
        @(negedge clk);
        req_valid   = 1'b0;
        data        = 8'd9;
        _portsel_in = 1'b0;
        @(negedge clk);
        _portsel_in = 1'b1;
        check("abort_strobe_active", _port_sel_wr, 16'hFFEF);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_wr", _port_sel_wr, 16'hFFFF);
        check("abort_rd", _port_sel_rd, 16'hFFFF);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("abort_no_done", done, 0);
        end
        // Address register was reset and the shadow dropped: both hit port 0
        send(1'b0, 4'd0, PULSE, 1'b0, 8'd0);
        send(1'b1, 4'd0, PULSE, 1'b0, 8'd0);

`ifdef PORT_WAIT_EN
        // Slow port holds the strobe for 5 cycles
        load(8'd7);
        fork
            send(1'b1, 4'd7, 5, 1'b0, 8'd0);
            begin
                int n;
                n = 0;
                @(negedge clk);
                while (_port_sel_wr === 16'hFFFF && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                if (_port_sel_wr === 16'hFFFF) check("wait_strobe_timeout", 0, 1);
                port_wait = 1'b1;
                repeat (4) @(negedge clk);
                port_wait = 1'b0;
            end
        join
        send(1'b1, 4'd7, PULSE, 1'b0, 8'd0);
`endif

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running exp=finished");
        $fatal(1);
    end

endmodule
